// File: rtl/nibble_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_ram_arbiter
//  Description : Shares the single-port 640-nibble system RAM between the CPU
//                bus (fixed priority) and an auxiliary requester (DMA/LCD).
//                A streak counter forces an aux slot after MAX_CPU_STREAK
//                consecutive CPU wins while aux is waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_ram_arbiter #(
  parameter int                    ADDR_WIDTH     = 12,
  parameter int                    DATA_WIDTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] RAM_LIMIT      = 12'h280,
  parameter int                    MAX_CPU_STREAK = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // CPU bus
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  // auxiliary requester
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [ADDR_WIDTH-1:0] aux_addr,
  input  logic [DATA_WIDTH-1:0] aux_wdata,
  output logic                  aux_ready,
  output logic                  aux_rvalid,
  output logic [DATA_WIDTH-1:0] aux_rdata,
  // RAM array
  output logic [9:0]            ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [3:0] c_max_streak = 4'(MAX_CPU_STREAK);

  // A zero streak limit would starve the CPU forever; >15 overflows the counter.
  if ((MAX_CPU_STREAK < 1) || (MAX_CPU_STREAK > 15)) begin : g_bad_max_streak
    $error("nibble_ram_arbiter: MAX_CPU_STREAK must be in 1..15");
  end

  logic [3:0]            r_streak;
  logic                  r_cpu_rd;      // CPU in-range read accepted last cycle
  logic                  r_aux_pend;    // aux read accepted last cycle
  logic                  r_aux_in;      // that aux read was in range
  logic [DATA_WIDTH-1:0] r_aux_hold;    // last delivered aux read data

  logic                  w_cpu_req;
  logic                  w_aux_req;
  logic                  w_grant_cpu;
  logic                  w_grant_aux;
  logic                  w_cpu_in;
  logic                  w_aux_in;
  logic                  w_aux_rvalid;
  logic [DATA_WIDTH-1:0] w_aux_new;

  // Requests are masked while reset is held so nothing reaches the RAM.
  assign w_cpu_req   = cpu_req & ~reset;
  assign w_aux_req   = aux_req & ~reset;

  // Aux wins when alone or when the CPU has used up its streak allowance.
  assign w_grant_aux = w_aux_req & (~w_cpu_req | (r_streak == c_max_streak));
  assign w_grant_cpu = w_cpu_req & ~w_grant_aux;

  assign w_cpu_in    = (cpu_addr < RAM_LIMIT);
  assign w_aux_in    = (aux_addr < RAM_LIMIT);

  // RAM drive follows the winner; the CPU owns the bus when idle.
  assign ram_addr    = w_grant_aux ? aux_addr[9:0] : cpu_addr[9:0];
  assign ram_wdata   = w_grant_aux ? aux_wdata     : cpu_wdata;
  assign ram_we      = (w_grant_cpu & cpu_we & w_cpu_in) |
                       (w_grant_aux & aux_we & w_aux_in);

  assign cpu_stall   = w_cpu_req & w_grant_aux;
  assign aux_ready   = w_grant_aux;

  // Read return: RAM output is already registered, so only steer/zero it here.
  assign cpu_rdata    = (r_cpu_rd & ~reset) ? ram_rdata : '0;
  assign w_aux_rvalid = r_aux_pend & ~reset;
  assign w_aux_new    = r_aux_in ? ram_rdata : '0;
  assign aux_rvalid   = w_aux_rvalid;
  assign aux_rdata    = w_aux_rvalid ? w_aux_new : r_aux_hold;

  // Streak of CPU wins over a waiting aux; any aux win or aux idle clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= 4'd0;
    end else if (!aux_req || w_grant_aux) begin
      r_streak <= 4'd0;
    end else if (w_grant_cpu && (r_streak != c_max_streak)) begin
      r_streak <= r_streak + 4'd1;
    end
  end

  // Track accepted reads so their data can be returned one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_rd   <= 1'b0;
      r_aux_pend <= 1'b0;
      r_aux_in   <= 1'b0;
    end else begin
      r_cpu_rd   <= w_grant_cpu & ~cpu_we & w_cpu_in;
      r_aux_pend <= w_grant_aux & ~aux_we;
      r_aux_in   <= w_aux_in;
    end
  end

  // Hold the last aux read result between deliveries.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aux_hold <= '0;
    end else if (w_aux_rvalid) begin
      r_aux_hold <= w_aux_new;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nibble_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_ram_arbiter
//  Description : Directed self-checking bench for nibble_ram_arbiter with a
//                behavioural 1024x4 synchronous RAM attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [3:0]  cpu_wdata;
  logic        cpu_stall;
  logic [3:0]  cpu_rdata;
  logic        aux_req, aux_we;
  logic [11:0] aux_addr;
  logic [3:0]  aux_wdata;
  logic        aux_ready, aux_rvalid;
  logic [3:0]  aux_rdata;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata;

  logic [3:0]  mem [0:1023];

  int n_chk  = 0;
  int n_pass = 0;
  int n_wait;

  always #5 clk = ~clk;

  nibble_ram_arbiter #(
    .ADDR_WIDTH     (12),
    .DATA_WIDTH     (4),
    .RAM_LIMIT      (12'h280),
    .MAX_CPU_STREAK (8)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .aux_req    (aux_req),
    .aux_we     (aux_we),
    .aux_addr   (aux_addr),
    .aux_wdata  (aux_wdata),
    .aux_ready  (aux_ready),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Synchronous single-port RAM with one cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [11:0] a, input logic [3:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_aux(input logic req, input logic we, input logic [11:0] a, input logic [3:0] d);
    aux_req = req; aux_we = we; aux_addr = a; aux_wdata = d;
  endtask

  // Caller is at a negedge; counts cycles without aux_ready (bounded).
  task automatic wait_aux(output int n);
    n = 0;
    while (!aux_ready && n < 20) begin
      n++;
      step();
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_cpu(1'b1, 1'b1, 12'h010, 4'hF);
    set_aux(1'b1, 1'b0, 12'h010, 4'h0);
    // Reset state with requests present
    @(negedge clk);
    step();
    @(negedge clk);
    chk("rst_ram_we",    ram_we,     0);
    chk("rst_cpu_stall", cpu_stall,  0);
    chk("rst_aux_ready", aux_ready,  0);
    chk("rst_aux_rvalid",aux_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata,  0);
    chk("rst_aux_rdata", aux_rdata,  0);
    step();
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 12'h000, 4'h0);
    set_aux(1'b0, 1'b0, 12'h000, 4'h0);
    step();

    // 1: CPU write then read back
    set_cpu(1'b1, 1'b1, 12'h123, 4'h5);
    @(negedge clk);
    chk("t1_we",    ram_we,    1);
    chk("t1_addr",  ram_addr,  10'h123);
    chk("t1_wdata", ram_wdata, 4'h5);
    chk("t1_stall", cpu_stall, 0);
    step();
    set_cpu(1'b1, 1'b0, 12'h123, 4'h0);
    @(negedge clk);
    chk("t1_rd_we", ram_we, 0);
    step();
    set_cpu(1'b0, 1'b0, 12'h000, 4'h0);
    @(negedge clk);
    chk("t1_rdata", cpu_rdata, 4'h5);
    step();
    @(negedge clk);
    chk("t1_rdata_idle", cpu_rdata, 4'h0);
    step();

    // 2: streak forcing with a continuously requesting CPU
    set_cpu(1'b1, 1'b1, 12'h010, 4'hA);
    step();
    set_cpu(1'b1, 1'b0, 12'h123, 4'h0);
    set_aux(1'b1, 1'b0, 12'h010, 4'h0);
    @(negedge clk);
    wait_aux(n_wait);
    chk("t2_cpu_wins1", n_wait, 8);
    chk("t2_stall",     cpu_stall, 1);
    chk("t2_ram_addr",  ram_addr, 10'h010);
    step();
    @(negedge clk);
    chk("t2_rvalid",    aux_rvalid, 1);
    chk("t2_rdata",     aux_rdata, 4'hA);
    chk("t2_cpu_rdata_stalled", cpu_rdata, 4'h0);
    wait_aux(n_wait);
    chk("t2_cpu_wins2", n_wait, 8);
    step();
    set_aux(1'b0, 1'b0, 12'h000, 4'h0);
    set_cpu(1'b0, 1'b0, 12'h000, 4'h0);
    @(negedge clk);
    chk("t2_rvalid2",   aux_rvalid, 1);
    step();
    @(negedge clk);
    chk("t2_rvalid_off", aux_rvalid, 0);
    chk("t2_rdata_hold", aux_rdata, 4'hA);

    // 3: aux-only write burst, then pipelined CPU read-back
    for (int i = 0; i < 16; i++) begin
      set_aux(1'b1, 1'b1, 12'h200 + 12'(i), 4'(i));
      @(negedge clk);
      chk($sformatf("t3_ready_%0d", i), aux_ready, 1);
      step();
    end
    set_aux(1'b0, 1'b0, 12'h000, 4'h0);
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) set_cpu(1'b1, 1'b0, 12'h200 + 12'(i), 4'h0);
      else        set_cpu(1'b0, 1'b0, 12'h000, 4'h0);
      @(negedge clk);
      if (i > 0) chk($sformatf("t3_rd_%0d", i - 1), cpu_rdata, 32'(i - 1));
      if (i == 1) chk("t3_no_rvalid", aux_rvalid, 0);
      step();
    end

    // 4: out-of-range accesses
    set_cpu(1'b1, 1'b1, 12'h280, 4'h7);
    @(negedge clk);
    chk("t4_we_280", ram_we, 0);
    step();
    set_cpu(1'b1, 1'b1, 12'h605, 4'h7);   // aliases 0x205 in 10 bits
    @(negedge clk);
    chk("t4_we_605", ram_we, 0);
    step();
    set_cpu(1'b1, 1'b0, 12'h605, 4'h0);
    set_aux(1'b1, 1'b0, 12'hF00, 4'h0);
    @(negedge clk);
    chk("t4_cpu_first", aux_ready, 0);
    step();
    set_cpu(1'b1, 1'b0, 12'h205, 4'h0);
    @(negedge clk);
    chk("t4_cpu_oor_rdata", cpu_rdata, 4'h0);
    step();
    set_cpu(1'b0, 1'b0, 12'h000, 4'h0);
    @(negedge clk);
    chk("t4_alias_intact", cpu_rdata, 4'h5);
    chk("t4_aux_ready", aux_ready, 1);
    step();
    set_aux(1'b0, 1'b0, 12'h000, 4'h0);
    @(negedge clk);
    chk("t4_aux_rvalid", aux_rvalid, 1);
    chk("t4_aux_rdata",  aux_rdata,  4'h0);
    step();

    // 5: reset right after an accepted aux read
    set_aux(1'b1, 1'b0, 12'h010, 4'h0);
    @(negedge clk);
    chk("t5_accept", aux_ready, 1);
    step();
    reset = 1'b1;
    set_cpu(1'b1, 1'b1, 12'h011, 4'h3);
    @(negedge clk);
    chk("t5_rvalid_rst",  aux_rvalid, 0);
    chk("t5_ready_rst",   aux_ready,  0);
    chk("t5_stall_rst",   cpu_stall,  0);
    chk("t5_we_rst",      ram_we,     0);
    chk("t5_cpu_rd_rst",  cpu_rdata,  0);
    step();
    @(negedge clk);
    chk("t5_rvalid_rst2", aux_rvalid, 0);
    chk("t5_rdata_rst2",  aux_rdata,  0);
    step();
    reset = 1'b0;
    set_cpu(1'b1, 1'b0, 12'h123, 4'h0);
    @(negedge clk);
    chk("t5_rvalid_post", aux_rvalid, 0);
    chk("t5_cpu_granted", cpu_stall,  0);
    wait_aux(n_wait);
    chk("t5_cpu_wins", n_wait, 8);
    step();
    set_aux(1'b0, 1'b0, 12'h000, 4'h0);
    @(negedge clk);
    chk("t5_rdata", aux_rdata, 4'hA);
    step();

    // 6: withdrawn aux request clears the streak
    set_aux(1'b1, 1'b0, 12'h010, 4'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t6_wait_%0d", i), aux_ready, 0);
      step();
    end
    set_aux(1'b0, 1'b0, 12'h010, 4'h0);
    step();
    set_aux(1'b1, 1'b0, 12'h010, 4'h0);
    @(negedge clk);
    wait_aux(n_wait);
    chk("t6_cpu_wins", n_wait, 8);
    step();
    set_aux(1'b0, 1'b0, 12'h000, 4'h0);
    set_cpu(1'b0, 1'b0, 12'h000, 4'h0);
    @(negedge clk);
    chk("t6_rvalid", aux_rvalid, 1);
    chk("t6_rdata",  aux_rdata,  4'hA);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_ram_arbiter.md
Name: nibble_ram_arbiter

Overview:
Shares the single-port 640-nibble system RAM (0x000–0x27F) between the CPU core bus and an auxiliary requester (savestate/debug DMA or LCD scanout engine). The CPU has fixed priority. A streak counter guarantees the auxiliary port a slot after a bounded number of consecutive CPU wins. It sits between the CPU memory bus and the RAM array, below the I/O-region decode in the SoC wrapper.

Parameters:
ADDR_WIDTH, 12, bus address width for both requesters
DATA_WIDTH, 4, nibble data width
RAM_LIMIT, 12'h280, first address outside RAM; accesses at or above it never reach the RAM
MAX_CPU_STREAK, 8, consecutive CPU grants while aux is pending before aux is forced a slot (range 1–15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request this cycle
cpu_we  in  1  CPU write enable (1 = write)
cpu_addr  in  12  CPU nibble address
cpu_wdata  in  4  CPU write data
cpu_stall  out  1  CPU access not taken this cycle; CPU must hold its request
cpu_rdata  out  4  registered CPU read data
aux_req  in  1  aux access request; held until aux_ready
aux_we  in  1  aux write enable
aux_addr  in  12  aux nibble address
aux_wdata  in  4  aux write data
aux_ready  out  1  aux access accepted this cycle (handshake completes when aux_req & aux_ready)
aux_rvalid  out  1  one-cycle pulse: aux_rdata valid
aux_rdata  out  4  registered aux read data
ram_addr  out  10  RAM address (addr[9:0] of the granted requester)
ram_we  out  1  RAM write strobe
ram_wdata  out  4  RAM write data
ram_rdata  in  4  RAM read data, one-cycle synchronous latency

Behaviour:
- At most one RAM access per cycle. The grant decision is combinational from the current inputs and the streak count.
- Grant rules, evaluated each cycle:
  - no requests -> idle
  - cpu_req only -> CPU
  - aux_req only -> AUX
  - both requesting and streak < MAX_CPU_STREAK -> CPU
  - both requesting and streak == MAX_CPU_STREAK -> AUX
- cpu_stall = cpu_req & AUX granted. aux_ready = AUX granted.
- Streak counter (4-bit):
  - increments on each CPU grant while aux_req = 1
  - clears on any AUX grant or any cycle with aux_req = 0
  - saturates at MAX_CPU_STREAK
- RAM drive:
  - ram_addr/ram_wdata come from the granted requester; when idle they take the CPU values.
  - ram_we = granted & we & (addr < RAM_LIMIT).
  - Out-of-range writes are dropped.
- Read return:
  - cpu_rdata is registered. The cycle after an accepted CPU read it equals ram_rdata, or 0 if the address was ≥ RAM_LIMIT. In every other cycle it is 0.
  - aux_rvalid pulses for one cycle after an accepted aux read, with aux_rdata = ram_rdata (or 0 if out of range). aux_rdata holds its last value otherwise.
  - Writes produce no rvalid.
- Read of an address written in the immediately preceding cycle returns the new data. There is no same-cycle hazard because the RAM is single-port.
- Latency: 1 cycle grant-to-data for both ports. Back-to-back accesses at full rate are supported.
- Aux must hold aux_addr, aux_we and aux_wdata stable while aux_req = 1 and aux_ready = 0. Dropping aux_req before acceptance cancels the request and clears the streak.
- Reset (synchronous, active-high):
  - streak = 0, cpu_rdata = 0, aux_rdata = 0, aux_rvalid = 0
  - while reset = 1: ram_we = 0, aux_ready = 0, cpu_stall = 0
  - a read accepted in the cycle before reset produces no rvalid after reset
- Any DATA_WIDTH/ADDR_WIDTH mismatch is a lint error. MAX_CPU_STREAK = 0 is illegal; an elaboration assertion rejects it.

Test Plan:
1. CPU write 0x5 @0x123, then CPU read @0x123 -> ram_we pulses once with ram_addr = 0x123; cpu_rdata = 0x5 one cycle after the read; cpu_stall stays 0.
2. cpu_req held high continuously while aux reads @0x010 (preloaded 0xA), MAX_CPU_STREAK = 8 -> 8 CPU grants, then cycle 9 has aux_ready = 1 and cpu_stall = 1; next cycle aux_rvalid = 1, aux_rdata = 0xA; the streak restarts and the next aux gets in after 8 more CPU grants.
3. Aux-only burst of writes 0x0–0xF to @0x200–0x20F -> aux_ready = 1 every cycle; CPU reads afterwards return the written values.
4. CPU write 0x7 @0x280 and aux read @0xF00 -> ram_we stays 0; aux_rvalid pulses with aux_rdata = 0; cpu_rdata = 0.
5. Aux read accepted, then reset asserted the next cycle for 2 cycles -> aux_rvalid stays 0, all outputs read as 0, and the streak is 0 after release (the first contended cycle grants CPU).
6. Aux request withdrawn after 5 contended cycles, then reissued -> 8 further CPU grants are required before aux_ready.
